// File: rtl/nim_pkg.sv
// rtl/nim_pkg.sv - shared state encoding and pile-slice helpers for the nim referee
package nim_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_CHECK     = 3'd2,
    S_ROUND_END = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam int DEF_NPILE = 10;
  localparam int DEF_PW    = 4;
  localparam int DEF_RW    = 3;

  // Pile i occupies bits [pile_lo(i,pw) +: pw] of any packed pile vector.
  function automatic int pile_lo(input int idx, input int pw);
    return idx * pw;
  endfunction

endpackage

// File: rtl/nim_referee_move_check.sv
// rtl/nim_referee_move_check.sv - combinational move legality and all-piles-zero detect
module nim_move_check
  import nim_pkg::*;
#(
  parameter int NPILE = DEF_NPILE,
  parameter int PW    = DEF_PW,
  localparam int SW   = (NPILE > 1) ? $clog2(NPILE) : 1
) (
  input  logic [NPILE*PW-1:0] piles,
  input  logic [SW-1:0]       sel_index,
  input  logic [PW-1:0]       new_value,
  output logic                legal,
  output logic                all_zero
);

  logic [PW-1:0] w_sel_val;
  logic          w_in_range;

  always_comb begin
    w_sel_val  = '0;
    w_in_range = 1'b0;
    for (int i = 0; i < NPILE; i++) begin
      if (int'(sel_index) == i) begin
        w_sel_val  = piles[pile_lo(i, PW) +: PW];
        w_in_range = 1'b1;
      end
    end
  end

  assign legal    = w_in_range && (new_value < w_sel_val);
  assign all_zero = ~|piles;

endmodule

// File: rtl/nim_referee.sv
// rtl/nim_referee.sv - nim match referee: validates moves, scores rounds, declares the match winner
module nim_referee
  import nim_pkg::*;
#(
  parameter int NPILE = DEF_NPILE,
  parameter int PW    = DEF_PW,
  parameter int RW    = DEF_RW,
  localparam int SW   = (NPILE > 1) ? $clog2(NPILE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RW-1:0]       target,
  input  logic [NPILE*PW-1:0] init_piles,
  input  logic                commit,
  input  logic [SW-1:0]       sel_index,
  input  logic [PW-1:0]       new_value,
  input  logic                abort,
  output logic [NPILE*PW-1:0] piles,
  output logic                player,
  output logic [RW-1:0]       score0,
  output logic [RW-1:0]       score1,
  output logic                move_err,
  output logic                busy,
  output logic                match_over,
  output logic                winner
);

  state_t              r_state, w_next;
  logic [NPILE*PW-1:0] r_piles, r_shadow;
  logic                r_player, r_starter, r_winner, r_move_err;
  logic [RW-1:0]       r_score0, r_score1, r_target;

  logic          w_legal, w_all_zero;
  logic          w_load, w_err, w_apply, w_toggle, w_score, w_done, w_reload;
  logic [RW-1:0] w_mover_score, w_inc;

  nim_move_check #(.NPILE(NPILE), .PW(PW)) u_check (
    .piles     (r_piles),
    .sel_index (sel_index),
    .new_value (new_value),
    .legal     (w_legal),
    .all_zero  (w_all_zero)
  );

  assign w_mover_score = r_player ? r_score1 : r_score0;
  assign w_inc         = (&w_mover_score) ? w_mover_score : w_mover_score + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_err    = 1'b0;
    w_apply  = 1'b0;
    w_toggle = 1'b0;
    w_score  = 1'b0;
    w_done   = 1'b0;
    w_reload = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (~|init_piles) begin
              w_err = 1'b1;
            end else begin
              w_load = 1'b1;
              w_next = S_PLAY;
            end
          end
        end
        S_PLAY: begin
          if (commit) begin
            if (w_legal) begin
              w_apply = 1'b1;
              w_next  = S_CHECK;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        S_CHECK: begin
          // Normal play: whoever empties the last pile takes the round.
          if (w_all_zero) begin
            w_score = 1'b1;
            if (w_inc == r_target) begin
              w_done = 1'b1;
              w_next = S_DONE;
            end else begin
              w_next = S_ROUND_END;
            end
          end else begin
            w_toggle = 1'b1;
            w_next   = S_PLAY;
          end
        end
        S_ROUND_END: begin
          w_reload = 1'b1;
          w_next   = S_PLAY;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_piles    <= '0;
      r_shadow   <= '0;
      r_player   <= 1'b0;
      r_starter  <= 1'b0;
      r_score0   <= '0;
      r_score1   <= '0;
      r_target   <= RW'(1);
      r_winner   <= 1'b0;
      r_move_err <= 1'b0;
    end else begin
      r_move_err <= w_err;
      if (w_load) begin
        r_piles   <= init_piles;
        r_shadow  <= init_piles;
        r_target  <= (target == '0) ? RW'(1) : target;
        r_score0  <= '0;
        r_score1  <= '0;
        r_player  <= 1'b0;
        r_starter <= 1'b0;
        r_winner  <= 1'b0;
      end else if (w_reload) begin
        r_piles   <= r_shadow;
        r_player  <= ~r_starter;
        r_starter <= ~r_starter;
      end else if (w_apply) begin
        for (int i = 0; i < NPILE; i++) begin
          if (int'(sel_index) == i) r_piles[pile_lo(i, PW) +: PW] <= new_value;
        end
      end
      if (w_toggle) r_player <= ~r_player;
      if (w_score) begin
        if (r_player) r_score1 <= w_inc;
        else          r_score0 <= w_inc;
      end
      if (w_done) r_winner <= r_player;
    end
  end

  assign piles      = r_piles;
  assign player     = r_player;
  assign score0     = r_score0;
  assign score1     = r_score1;
  assign move_err   = r_move_err;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign match_over = (r_state == S_DONE);
  assign winner     = r_winner;

endmodule

// File: tb/tb_nim_referee.sv
// tb/tb_nim_referee.sv - directed scoreboard bench for nim_referee
module tb_nim_referee;

  localparam int NPILE = 10;
  localparam int PW    = 4;
  localparam int RW    = 3;
  localparam int SW    = $clog2(NPILE);

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [RW-1:0]       target;
  logic [NPILE*PW-1:0] init_piles;
  logic                commit;
  logic [SW-1:0]       sel_index;
  logic [PW-1:0]       new_value;
  logic                abort;
  logic [NPILE*PW-1:0] piles;
  logic                player;
  logic [RW-1:0]       score0, score1;
  logic                move_err, busy, match_over, winner;

  nim_referee #(.NPILE(NPILE), .PW(PW), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .target     (target),
    .init_piles (init_piles),
    .commit     (commit),
    .sel_index  (sel_index),
    .new_value  (new_value),
    .abort      (abort),
    .piles      (piles),
    .player     (player),
    .score0     (score0),
    .score1     (score1),
    .move_err   (move_err),
    .busy       (busy),
    .match_over (match_over),
    .winner     (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%0h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failed++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [RW-1:0] t, input logic [NPILE*PW-1:0] p);
    start = 1'b1; target = t; init_piles = p;
    tick();
    start = 1'b0;
  endtask

  // Commit then let CHECK resolve.
  task automatic do_move(input int idx, input int val);
    commit = 1'b1; sel_index = SW'(idx); new_value = PW'(val);
    tick();
    commit = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; target = '0; init_piles = '0;
    commit = 1'b0; sel_index = '0; new_value = '0; abort = 1'b0;
    #3;
    exp("rst_piles", 64'h0);   chk(64'(piles));
    exp("rst_player", 64'h0);  chk(64'(player));
    exp("rst_score0", 64'h0);  chk(64'(score0));
    exp("rst_score1", 64'h0);  chk(64'(score1));
    exp("rst_move_err", 64'h0); chk(64'(move_err));
    exp("rst_busy", 64'h0);    chk(64'(busy));
    exp("rst_over", 64'h0);    chk(64'(match_over));
    exp("rst_winner", 64'h0);  chk(64'(winner));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // commit in IDLE is ignored
    commit = 1'b1; sel_index = '0; new_value = '0;
    exp("idle_commit_err", 64'h0);
    tick();
    commit = 1'b0;
    chk(64'(move_err));

    // single pile match
    exp("m1_busy", 64'h1); exp("m1_piles", 64'h3);
    do_start(3'd1, 40'h00_0000_0003);
    chk(64'(busy)); chk(64'(piles));
    exp("m1_piles_zero", 64'h0); exp("m1_over", 64'h1); exp("m1_winner", 64'h0);
    exp("m1_score0", 64'h1); exp("m1_busy_done", 64'h0);
    do_move(0, 0);
    chk(64'(piles)); chk(64'(match_over)); chk(64'(winner)); chk(64'(score0)); chk(64'(busy));

    // abort from DONE, then start with all-zero piles
    abort = 1'b1; tick(); abort = 1'b0;
    exp("abort_over", 64'h0); chk(64'(match_over));
    exp("zero_err", 64'h1); exp("zero_busy", 64'h0); exp("zero_over", 64'h0); exp("zero_err_once", 64'h0);
    do_start(3'd1, '0);
    chk(64'(move_err)); chk(64'(busy)); chk(64'(match_over));
    tick();
    chk(64'(move_err));

    // illegal moves
    do_start(3'd1, 40'h00_0000_0502);
    commit = 1'b1; sel_index = 4'd2; new_value = 4'd5;
    exp("eq_err", 64'h1); exp("eq_piles", 64'h502); exp("eq_player", 64'h0); exp("eq_busy", 64'h1);
    tick(); commit = 1'b0;
    chk(64'(move_err)); chk(64'(piles)); chk(64'(player)); chk(64'(busy));
    exp("eq_err_clear", 64'h0);
    tick();
    chk(64'(move_err));
    commit = 1'b1; sel_index = 4'd10; new_value = 4'd0;
    exp("oob_err", 64'h1); exp("oob_piles", 64'h502);
    tick(); commit = 1'b0;
    chk(64'(move_err)); chk(64'(piles));
    // legal boundary move value = pile-1
    exp("legal_piles", 64'h402); exp("legal_player", 64'h1); exp("legal_err", 64'h0);
    do_move(2, 4);
    chk(64'(piles)); chk(64'(player)); chk(64'(move_err));

    // commit + abort same cycle
    commit = 1'b1; abort = 1'b1; sel_index = 4'd0; new_value = 4'd0;
    exp("ab_busy", 64'h0); exp("ab_piles", 64'h402); exp("ab_err", 64'h0);
    tick(); commit = 1'b0; abort = 1'b0;
    chk(64'(busy)); chk(64'(piles)); chk(64'(move_err));

    // two-round target, alternating starters
    do_start(3'd2, 40'h00_0000_0011);
    do_move(0, 0);
    exp("r1_player", 64'h1); chk(64'(player));
    exp("r1_score1", 64'h1); exp("r1_score0", 64'h0); exp("r1_busy", 64'h1);
    do_move(1, 0);
    chk(64'(score1)); chk(64'(score0)); chk(64'(busy));
    exp("r2_reload", 64'h11); exp("r2_player", 64'h1);
    tick();
    chk(64'(piles)); chk(64'(player));
    do_move(0, 0);
    do_move(1, 0);
    exp("r2_score0", 64'h1); chk(64'(score0));
    exp("r3_player", 64'h0);
    tick();
    chk(64'(player));
    do_move(0, 0);
    exp("r3_over", 64'h1); exp("r3_winner", 64'h1); exp("r3_score1", 64'h2);
    do_move(1, 0);
    chk(64'(match_over)); chk(64'(winner)); chk(64'(score1));

    // target 0 acts as 1; restart from DONE
    do_start(3'd0, 40'h00_0000_0001);
    exp("t0_over", 64'h1); exp("t0_score0", 64'h1);
    do_move(0, 0);
    chk(64'(match_over)); chk(64'(score0));

    // asynchronous reset during CHECK
    do_start(3'd1, 40'h00_0000_0003);
    commit = 1'b1; sel_index = 4'd0; new_value = 4'd2;
    tick(); commit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp("ar_piles", 64'h0); exp("ar_busy", 64'h0); exp("ar_player", 64'h0); exp("ar_over", 64'h0);
    chk(64'(piles)); chk(64'(busy)); chk(64'(player)); chk(64'(match_over));
    tick();
    rst_n = 1'b1;
    tick();

    if (sb.size() != 0) begin
      tests++; failed++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/nim_referee.md
NIM_REFEREE -- requirements
Module: nim_referee

Interface
REQ-001 SHALL have parameter NPILE, default 10, number of piles.
REQ-002 SHALL have parameter PW, default 4, bits per pile value.
REQ-003 SHALL have parameter RW, default 3, width of round-target and score counters.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a match.
REQ-007 target  input  RW  round wins needed to take the match; sampled on start.
REQ-008 init_piles  input  NPILE*PW  starting pile values; sampled on start; pile i at [i*PW +: PW].
REQ-009 commit  input  1  one-cycle pulse; submits a move.
REQ-010 sel_index  input  clog2(NPILE)  pile addressed by the move.
REQ-011 new_value  input  PW  value the selected pile becomes.
REQ-012 abort  input  1  returns the block to IDLE.
REQ-013 piles  output  NPILE*PW  current pile values.
REQ-014 player  output  1  player to move (0/1).
REQ-015 score0, score1  output  RW each  round wins per player.
REQ-016 move_err  output  1  one-cycle pulse on a rejected move or start.
REQ-017 busy  output  1  high in any state except IDLE and DONE.
REQ-018 match_over  output  1  high while in DONE.
REQ-019 winner  output  1  match winner; valid while match_over.

Function
REQ-020 FSM states: IDLE, PLAY, CHECK, ROUND_END, DONE.
REQ-021 IDLE + start with init_piles non-zero: latch init_piles into a shadow register and piles; latch target (0 treated as 1); clear scores; player=0; go to PLAY next cycle.
REQ-022 IDLE + start with init_piles all zero: stay IDLE; pulse move_err.
REQ-023 Move legality: legal iff sel_index<NPILE and new_value < piles[sel_index].
REQ-024 PLAY + legal commit at cycle n: piles[sel_index]=new_value visible at n+1; state CHECK at n+1.
REQ-025 PLAY + illegal commit: pulse move_err at n+1; piles, player and state unchanged.
REQ-026 commit outside PLAY: ignored, no move_err.
REQ-027 CHECK, piles not all zero: toggle player; back to PLAY (player visible at n+2).
REQ-028 CHECK, all piles zero: mover wins the round (normal play); increment mover's score, saturating at 2^RW-1.
REQ-029 CHECK, incremented score equals latched target: go DONE with winner=mover; else go ROUND_END.
REQ-030 ROUND_END: reload piles from shadow; player = opposite of the previous round's starting player; go PLAY next cycle.
REQ-031 DONE: hold piles, scores and winner; start behaves as in IDLE.
REQ-032 abort in any state: go IDLE next cycle; piles and scores held; abort outranks start and commit in the same cycle.
REQ-033 start outside IDLE/DONE: ignored.
REQ-034 move_err never high two consecutive cycles from one event.

Reset
REQ-035 rst_n low: state IDLE, piles 0, shadow 0, player 0, scores 0, target 1, winner 0, move_err 0, busy 0, match_over 0.
REQ-036 Reset asserted mid-match discards the match immediately; no partial commit survives.

Structure
REQ-037 State encoding enum and pile-slice helper constants SHALL live in the shared game package.
REQ-038 Legality check plus all-zero detect SHALL be one combinational sub-module, nim_move_check.
REQ-039 Expected size 120-400 lines RTL.

Verification
REQ-040 Reset, start target=1, piles={pile0=3, others 0}, commit idx0 val0 -> piles all zero, score0=1, DONE, winner=0, match_over=1.
REQ-041 PLAY, pile2=5, commit idx2 val5 (not less) and commit idx10 (NPILE=10) -> move_err pulse each, piles and player unchanged.
REQ-042 target=2, piles {1,1}: P0 idx0->0, P1 idx1->0 -> score1=1, ROUND_END reload {1,1}, player=1 starts round 2.
REQ-043 start with init_piles=0 -> move_err pulse, stays IDLE, busy=0.
REQ-044 commit and abort same cycle in PLAY -> IDLE, pile value unchanged.
REQ-045 rst_n low during CHECK -> all outputs at reset values asynchronously.
